motion_segment_executor: RTL
============================

Name: motion_segment_executor

Overview:
- Downstream consumer of the motion-segment fifo; drives one stepper axis.
- Pops one 32-bit segment at a time over the fifo read handshake (data_available / data_request / data).
- Executes the segment as a train of fixed-width step pulses at a programmed period, with direction setup time honoured.
- Sits between the fifo read port and the step/dir pins; exports busy/underrun status for the LED/debug logic.

Parameters:
- PulseWidth, 8: step_out high time in clk cycles (>=1).
- DirSetup, 16: clk cycles between a dir_out change and the next step rising edge.
- ReadLatency, 1: clk cycles from data_request to data being valid (>=1).
- MinPeriod, 16: floor applied to the segment period (must be > PulseWidth).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  allows fetching new segments; the running segment always completes
- data_available  in  1  fifo not empty
- data_request  out  1  one-cycle pop strobe to fifo
- data  in  32  segment: [31]=direction, [30:16]=step count N (15b unsigned), [15:0]=period P in clk cycles
- step_out  out  1  step pulse
- dir_out  out  1  direction level
- busy  out  1  high in any state other than IDLE
- underrun  out  1  sticky: a segment ended with enable=1 and data_available=0; cleared by reset or a successful fetch

Behaviour:
- Reset (synchronous, dominant over all other inputs, usable mid-segment):
  - Outputs: step_out=0, dir_out=0, data_request=0, busy=0, underrun=0.
  - Internal: state=IDLE, all counters=0.
  - Mid-segment reset drops step_out the next cycle; the rest of the segment is discarded.
- States: IDLE, FETCH, SETUP, RUN.
- IDLE:
  - If enable && data_available: data_request=1 for exactly this cycle, then go to FETCH.
- FETCH:
  - Counts ReadLatency cycles after the request cycle.
  - On the last cycle, latch data: N, effective period Pe = max(P, MinPeriod), new_dir = data[31].
  - If new_dir != dir_out: dir_out <= new_dir and go to SETUP; otherwise go directly to RUN.
- SETUP:
  - step_out=0 for exactly DirSetup cycles, then go to RUN.
- RUN:
  - Period counter c runs 0..Pe-1; step_out = (c < PulseWidth) && (N != 0).
  - At c = Pe-1: if remaining steps > 1, decrement and set c=0.
  - Otherwise the segment ends:
    - If enable && data_available: assert data_request in that same cycle and go to FETCH (back-to-back, no gap).
    - Else go to IDLE; set underrun if enable=1.
- N=0 is a dwell: one period Pe with step_out held low; dir_out is still updated (with SETUP applied if it changes).
- Step timing: first rising edge of step_out occurs in the first RUN cycle. Consecutive rising edges are exactly Pe cycles apart, including across back-to-back segments when direction is unchanged.
- data_request never asserts while data_available=0. At most one pop is outstanding at a time.
- enable deasserted mid-segment: the current segment finishes fully, then the block goes to IDLE with no underrun.
- Width rules:
  - P=0xFFFF is legal: period counter is 16 bits.
  - Step counter is 15 bits; N=0x7FFF yields 32767 pulses.
  - The max() comparison is unsigned.

Test Plan:
- Reset, then one segment {dir=0, N=3, P=20}, ReadLatency=1 → one data_request pulse; 3 pulses each 8 cycles high, rising edges 20 cycles apart; no SETUP; busy falls after 60 RUN cycles; underrun=1 because enable=1 with the fifo empty.
- Segment {dir=1, N=2, P=40} → dir_out rises in the latch cycle; first step rising edge exactly 16 cycles later; pulses 40 cycles apart.
- Two queued segments, same dir, {N=2, P=30} then {N=1, P=50} → second data_request coincides with the last period cycle of the first segment; step rising edges at t, t+30, t+60; busy stays high throughout.
- Segment {N=4, P=5} → period clamped to 16; edges 16 cycles apart; step_out high 8 cycles per pulse.
- Dwell {dir=0, N=0, P=100} then {N=1, P=20} → step_out low for 100 cycles, then one pulse; no underrun.
- Reset asserted 3 cycles into a pulse → step_out=0 and busy=0 the following cycle; with enable=0 afterwards, no further data_request.

Source files
------------

// File: rtl/motion_segment_executor.sv
// motion_segment_executor
//   Pops 32-bit motion segments from the segment fifo and plays each one out
//   on a single stepper axis as a train of fixed-width step pulses. Direction
//   changes are followed by a setup gap before the next step edge.
//
// Ports
//   clk             system clock
//   reset           synchronous, active-high; dominant over every other input
//   enable          allows new segments to be fetched (running one completes)
//   data_available  fifo not empty
//   data_request    one-cycle pop strobe to the fifo
//   data            segment: [31] dir, [30:16] step count N, [15:0] period P
//   step_out        step pulse, PulseWidth cycles high, one per period
//   dir_out         direction level
//   busy            high whenever the controller is not IDLE
//   underrun        sticky: a segment ended with enable=1 and the fifo empty;
//                   cleared by reset or by the next segment being latched
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for enable && data_available; pop issued on leaving
// FETCH | waiting out the fifo read latency, latch segment on last cycle
// SETUP | direction just changed, hold step low for DirSetup cycles
// RUN   | emitting one period per step (a single silent period if N=0)

module motion_segment_executor #(
  parameter int PulseWidth  = 8,
  parameter int DirSetup    = 16,
  parameter int ReadLatency = 1,
  parameter int MinPeriod   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        data_available,
  output logic        data_request,
  input  logic [31:0] data,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SETUP = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int FetchW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
  localparam int SetupW = (DirSetup > 1) ? $clog2(DirSetup) : 1;

  localparam logic [FetchW-1:0] FetchLoad = FetchW'(ReadLatency - 1);
  localparam logic [SetupW-1:0] SetupLoad = SetupW'(DirSetup - 1);
  localparam logic [15:0]       MinP      = 16'(MinPeriod);
  localparam logic [15:0]       Pw        = 16'(PulseWidth);
  localparam logic              PwMulti   = (PulseWidth > 1);

  state_t            state;
  logic [FetchW-1:0] fetch_cnt;
  logic [SetupW-1:0] setup_cnt;
  logic [15:0]       period_cnt;   // counts down Pe-1 .. 0 within a period
  logic [14:0]       step_cnt;     // steps remaining, including the current one
  logic [15:0]       pe;           // effective period of the running segment
  logic              chain;        // current fetch was issued back-to-back
  logic              step_q;

  logic        seg_dir;
  logic [14:0] seg_n;
  logic [15:0] seg_p;
  logic [15:0] seg_pe;
  logic        fetch_done;
  logic        period_end;
  logic        seg_end;
  logic        pop_ok;
  logic        launch;
  logic [15:0] step_hi_th;

  assign seg_dir = data[31];
  assign seg_n   = data[30:16];
  assign seg_p   = data[15:0];
  assign seg_pe  = (seg_p < MinP) ? MinP : seg_p;

  assign fetch_done = (state == FETCH) && (fetch_cnt == '0);
  assign period_end = (state == RUN) && (period_cnt == 16'd0);
  assign seg_end    = period_end && (step_cnt <= 15'd1);
  assign pop_ok     = enable && data_available && !reset;

  // The pop strobe is decoded from the current state so that it is always
  // qualified by the live data_available and lands in the last period cycle
  // of a segment when chaining.
  assign data_request = pop_ok && ((state == IDLE) || seg_end);

  // On a back-to-back fetch with no direction change, the latch cycle is the
  // first cycle of the new segment's first period, so the step edge spacing
  // stays exactly Pe across the segment boundary. That first cycle is driven
  // straight from the freshly valid fifo word; every later cycle is registered.
  assign launch   = fetch_done && chain && (seg_dir == dir_out) &&
                    (seg_n != 15'd0) && !reset;
  assign step_out = step_q | launch;

  // step is high while c < PulseWidth, i.e. while period_cnt >= Pe - PulseWidth
  assign step_hi_th = pe - Pw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_cnt  <= '0;
      setup_cnt  <= '0;
      period_cnt <= 16'd0;
      step_cnt   <= 15'd0;
      pe         <= 16'd0;
      chain      <= 1'b0;
      step_q     <= 1'b0;
      dir_out    <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          step_q <= 1'b0;
          if (pop_ok) begin
            state     <= FETCH;
            fetch_cnt <= FetchLoad;
            chain     <= 1'b0;
            busy      <= 1'b1;
          end
        end

        FETCH: begin
          if (fetch_cnt != '0) begin
            fetch_cnt <= fetch_cnt - 1'b1;
          end else begin
            step_cnt <= seg_n;
            pe       <= seg_pe;
            underrun <= 1'b0;
            if (seg_dir != dir_out) begin
              dir_out   <= seg_dir;
              setup_cnt <= SetupLoad;
              step_q    <= 1'b0;
              state     <= SETUP;
            end else begin
              state <= RUN;
              if (chain) begin
                // latch cycle already served as c=0
                period_cnt <= seg_pe - 16'd2;
                step_q     <= (seg_n != 15'd0) && PwMulti;
              end else begin
                period_cnt <= seg_pe - 16'd1;
                step_q     <= (seg_n != 15'd0);
              end
            end
          end
        end

        SETUP: begin
          if (setup_cnt != '0) begin
            setup_cnt <= setup_cnt - 1'b1;
          end else begin
            state      <= RUN;
            period_cnt <= pe - 16'd1;
            step_q     <= (step_cnt != 15'd0);
          end
        end

        RUN: begin
          if (period_cnt != 16'd0) begin
            period_cnt <= period_cnt - 16'd1;
            step_q     <= ((period_cnt - 16'd1) >= step_hi_th) &&
                          (step_cnt != 15'd0);
          end else if (step_cnt > 15'd1) begin
            step_cnt   <= step_cnt - 15'd1;
            period_cnt <= pe - 16'd1;
            step_q     <= 1'b1;
          end else if (pop_ok) begin
            state     <= FETCH;
            fetch_cnt <= FetchLoad;
            chain     <= 1'b1;
            step_q    <= 1'b0;
          end else begin
            state    <= IDLE;
            step_q   <= 1'b0;
            busy     <= 1'b0;
            underrun <= underrun | enable;
          end
        end

        default: begin
          state  <= IDLE;
          step_q <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
